hls_test_sequencer: RTL



---
 rtl/hls_test_sequencer_if.sv | 14 +
 rtl/hls_test_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/hls_test_sequencer_if.sv
// Method-call channel bundle between the test sequencer and an HLS-generated module.
// Handshake: the master holds req[i] high until it sees busy[i] high (the call is then accepted).
// The slave keeps busy high while executing. The return value is valid in the first cycle busy falls low after acceptance.
interface hls_test_sequencer_if #(
  parameter int NUM_TESTS = 4,
  parameter int RET_WIDTH = 32
);
  logic [NUM_TESTS-1:0]           test_req;
  logic [NUM_TESTS-1:0]           test_busy;
  logic [NUM_TESTS*RET_WIDTH-1:0] test_return;

  modport master (output test_req, input test_busy, input test_return);
  modport slave  (input test_req, output test_busy, output test_return);
endinterface

// File: rtl/hls_test_sequencer.sv
// Self-check sequencer: resets an HLS module, calls each enabled method once, and checks returns.
// The sequencer flags a channel on a wrong return or on a timeout, and reports pass/fail masks.
module hls_test_sequencer #(
  parameter int NUM_TESTS      = 4,
  parameter int RET_WIDTH      = 32,
  parameter int RESET_CYCLES   = 6,
  parameter int START_DELAY    = 92,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter logic [NUM_TESTS*RET_WIDTH-1:0] EXPECTED = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_TESTS-1:0]    test_enable,
  output logic                    dut_reset,
  hls_test_sequencer_if.master    dut_if,
  output logic                    done,
  output logic                    pass,
  output logic [NUM_TESTS-1:0]    fail_mask,
  output logic [NUM_TESTS-1:0]    timeout_mask,
  output logic [2:0]              dbg_state
);

  localparam int IW = $clog2(NUM_TESTS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DUT_RST = 3'd1,
    S_SETTLE  = 3'd2,
    S_SELECT  = 3'd3,
    S_REQ     = 3'd4,
    S_RUN     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                 state, state_n;
  logic [IW-1:0]          idx;
  logic [31:0]            cnt;
  logic [NUM_TESTS-1:0]   en_q;
  logic [NUM_TESTS-1:0]   sel_oh;
  logic [RET_WIDTH-1:0]   ret_sel, exp_sel;
  logic                   busy_sel, en_sel, last_idx, tmo, ret_ok;

  // One-hot channel decode avoids indexing past NUM_TESTS when idx has run off the end.
  always_comb begin
    sel_oh  = '0;
    ret_sel = '0;
    exp_sel = '0;
    for (int i = 0; i < NUM_TESTS; i++) begin
      sel_oh[i] = (idx == IW'(i));
      if (idx == IW'(i)) begin
        ret_sel = dut_if.test_return[i*RET_WIDTH +: RET_WIDTH];
        exp_sel = EXPECTED[i*RET_WIDTH +: RET_WIDTH];
      end
    end
  end

  assign busy_sel = |(dut_if.test_busy & sel_oh);
  assign en_sel   = |(en_q & sel_oh);
  assign last_idx = (idx == IW'(NUM_TESTS));
  assign tmo      = (cnt == 32'(TIMEOUT_CYCLES - 1));
  assign ret_ok   = (ret_sel == exp_sel);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_n = S_DUT_RST;
      S_DUT_RST:      if (cnt == 32'(RESET_CYCLES - 1)) state_n = S_SETTLE;
      // The settle window includes the index-clear cycle, so it is START_DELAY+1 cycles long.
      S_SETTLE:       if (cnt == 32'(START_DELAY)) state_n = S_SELECT;
      S_SELECT: begin
        if (last_idx)    state_n = S_DONE;
        else if (en_sel) state_n = S_REQ;
      end
      S_REQ: begin
        if (tmo)           state_n = S_SELECT;
        else if (busy_sel) state_n = S_RUN;
      end
      S_RUN: begin
        if (tmo || !busy_sel) state_n = S_SELECT;
      end
      default:        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      en_q         <= '0;
      pass         <= 1'b0;
      fail_mask    <= '0;
      timeout_mask <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            en_q         <= test_enable;
            fail_mask    <= '0;
            timeout_mask <= '0;
            pass         <= 1'b0;
            cnt          <= '0;
          end
        end
        S_DUT_RST: cnt <= (state_n == S_DUT_RST) ? cnt + 32'd1 : '0;
        S_SETTLE: begin
          idx <= '0;
          cnt <= (state_n == S_SETTLE) ? cnt + 32'd1 : '0;
        end
        S_SELECT: begin
          if (last_idx)     pass <= (fail_mask == '0);
          else if (!en_sel) idx  <= idx + 1'b1;
          else              cnt  <= '0;
        end
        S_REQ, S_RUN: begin
          cnt <= cnt + 32'd1;
          // Timeout wins over a completion seen in the same cycle.
          if (tmo) begin
            fail_mask    <= fail_mask | sel_oh;
            timeout_mask <= timeout_mask | sel_oh;
            idx          <= idx + 1'b1;
          end else if (state == S_RUN && !busy_sel) begin
            if (!ret_ok) fail_mask <= fail_mask | sel_oh;
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_reset       = (state == S_DUT_RST);
  assign dut_if.test_req = (state == S_REQ) ? sel_oh : '0;
  assign done            = (state == S_DONE);
  assign dbg_state       = state;

endmodule
